// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin system bus arbiter with registered responses.
// Define SYS_BUS_ARBITER_TIMEOUT_EN to compile in the hung-transaction watchdog.
module sys_bus_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_wr,
  input  logic [2:0]           m0_size,
  input  logic [AddrWidth-1:0] m0_addr,
  input  logic [DataWidth-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_done,
  output logic [DataWidth-1:0] m0_rdata,
  output logic                 m0_fault,
  input  logic                 m1_req,
  input  logic                 m1_wr,
  input  logic [2:0]           m1_size,
  input  logic [AddrWidth-1:0] m1_addr,
  input  logic [DataWidth-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_done,
  output logic [DataWidth-1:0] m1_rdata,
  output logic                 m1_fault,
  output logic                 bus_req,
  output logic                 bus_wr,
  output logic [2:0]           bus_size,
  output logic [AddrWidth-1:0] bus_addr,
  output logic [DataWidth-1:0] bus_wdata,
  input  logic                 bus_ack,
  input  logic                 bus_err,
  input  logic [DataWidth-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 pick;
  logic                 cap_en;
  logic                 cap_fault;
  logic [DataWidth-1:0] cap_rdata;
  logic [DataWidth-1:0] rdata_q;
  logic                 fault_q;
  logic                 busy;
  logic                 resp;

`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        expired;

  assign expired = (cnt_q == 16'(TimeoutCycles - 1));
`else
  logic unused_cfg;

  assign unused_cfg = ^32'(TimeoutCycles);
`endif

  // Tie goes to whichever master did not win last time.
  assign pick = m1_req & (~m0_req | ~last_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cap_en    = 1'b0;
    cap_rdata = bus_rdata;
    cap_fault = bus_err;
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          owner_d = pick;
          last_d  = pick;
          state_d = BUSY;
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (bus_ack) begin
          cap_en  = 1'b1;
          state_d = RESP;
        end
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
        else if (expired) begin
          cap_en    = 1'b1;
          cap_rdata = '0;
          cap_fault = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (cap_en) begin
        rdata_q <= cap_rdata;
        fault_q <= cap_fault;
      end
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy = (state_q == BUSY);
  assign resp = (state_q == RESP);

  assign m0_gnt   = (busy | resp) & ~owner_q;
  assign m1_gnt   = (busy | resp) & owner_q;
  assign m0_done  = resp & ~owner_q;
  assign m1_done  = resp & owner_q;
  assign m0_rdata = m0_done ? rdata_q : '0;
  assign m1_rdata = m1_done ? rdata_q : '0;
  assign m0_fault = m0_done & fault_q;
  assign m1_fault = m1_done & fault_q;

  // Attributes are held at zero outside BUSY.
  assign bus_req   = busy;
  assign bus_wr    = busy & (owner_q ? m1_wr : m0_wr);
  assign bus_size  = busy ? (owner_q ? m1_size : m0_size) : '0;
  assign bus_addr  = busy ? (owner_q ? m1_addr : m0_addr) : '0;
  assign bus_wdata = busy ? (owner_q ? m1_wdata : m0_wdata) : '0;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized scoreboard bench for sys_bus_arbiter.
// Reference model: round-robin grants, done one cycle after ack.
module tb_sys_bus_arbiter;

`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
  localparam int MAXDLY = 5;
`else
  localparam int TO = 255;
  localparam int MAXDLY = 3;
`endif
  localparam int NTX = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_fault;
  logic        m1_gnt, m1_done, m1_fault;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_req, bus_wr, bus_ack, bus_err;
  logic [2:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  sys_bus_arbiter #(
    .AddrWidth(32),
    .DataWidth(32),
    .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Fabric: random ack latency, occasional stray acks outside a request.
  int dly = -1;
  initial begin
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 0;
      bus_err = 0;
      if (bus_req) begin
        if (dly < 0) dly = $urandom_range(0, MAXDLY);
        if (dly == 0) begin
          bus_ack   = 1;
          bus_err   = ($urandom_range(0, 3) == 0);
          bus_rdata = $urandom;
          dly = -1;
        end else dly--;
      end else begin
        dly = -1;
        if ($urandom_range(0, 7) == 0) begin
          bus_ack   = 1;
          bus_err   = 1;
          bus_rdata = $urandom;
        end
      end
    end
  end

  // Reference model: free arbiter grants next cycle, ties alternate.
  bit       act = 0, pend = 0;
  logic [1:0] preq;
  logic     last_m = 0;
  int       win = 0, nb = 0, idle_at = 0;
  always @(negedge clk) if (chk_on) begin
    if (pend) begin
      pend = 0;
      chk("grant_latency", 64'(bus_req), 64'd1);
      win = (preq == 2'b11) ? int'(!last_m) : int'(preq[1]);
      last_m = win[0];
      act = 1;
      nb = 0;
    end else if (!act) chk("bus_req_idle", 64'(bus_req), 64'd0);
    if (act) begin
      nb++;
      chk("bus_req_busy", 64'(bus_req), 64'd1);
      chk("gnt0", 64'(m0_gnt), 64'(win == 0));
      chk("gnt1", 64'(m1_gnt), 64'(win == 1));
      chk("bus_addr", 64'(bus_addr), 64'(win == 1 ? m1_addr : m0_addr));
      chk("bus_wdata", 64'(bus_wdata),
          64'(win == 1 ? m1_wdata : m0_wdata));
      chk("bus_wr", 64'(bus_wr), 64'(win == 1 ? m1_wr : m0_wr));
      chk("bus_size", 64'(bus_size), 64'(win == 1 ? m1_size : m0_size));
      if (bus_ack) begin
        sbq.push_back('{win, bus_rdata, bus_err, cyc + 1});
        act = 0;
        idle_at = cyc + 2;
      end else if (nb == TO) begin
`ifdef SYS_BUS_ARBITER_TIMEOUT_EN
        sbq.push_back('{win, 32'h0, 1'b1, cyc + 1});
        act = 0;
        idle_at = cyc + 2;
`endif
      end
    end else if (cyc >= idle_at && (m0_req || m1_req)) begin
      pend = 1;
      preq = {m1_req, m0_req};
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  exp_t e;
  always @(negedge clk) if (chk_on) begin
    if (m0_done || m1_done) begin
      if (sbq.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("done0", 64'(m0_done), 64'(e.m == 0));
        chk("done1", 64'(m1_done), 64'(e.m == 1));
        chk("rdata", 64'(e.m == 1 ? m1_rdata : m0_rdata), 64'(e.rdata));
        chk("fault", 64'(e.m == 1 ? m1_fault : m0_fault), 64'(e.fault));
        chk("other_rdata", 64'(e.m == 1 ? m0_rdata : m1_rdata), 64'd0);
        chk("other_fault", 64'(e.m == 1 ? m0_fault : m1_fault), 64'd0);
      end
    end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
      chk("missing_done", 64'd0, 64'd1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int idle0, idle1, t;
  initial begin
    rst = 1;
    m0_req = 0; m0_wr = 1; m0_size = 3'h5;
    m0_addr = 32'hA5A5_0000; m0_wdata = 32'h1234;
    m1_req = 0; m1_wr = 1; m1_size = 3'h2;
    m1_addr = 32'h5A5A_0000; m1_wdata = 32'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
    chk("rst_done", 64'({m0_done, m1_done}), 64'd0);
    chk("rst_rdata", 64'(m0_rdata | m1_rdata), 64'd0);
    chk("rst_fault", 64'({m0_fault, m1_fault}), 64'd0);
    chk("rst_attr", 64'({bus_wr, bus_size, bus_addr}), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_on = 1;
    fork
      begin : mst0
        for (int n = 0; n < NTX; n++) begin
          idle0 = (n == 0) ? 0 : $urandom_range(0, 3);
          repeat (idle0) begin @(posedge clk); #1; end
          m0_wr = $urandom; m0_size = $urandom;
          m0_addr = $urandom; m0_wdata = $urandom;
          m0_req = 1;
          for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m0_done) break;
            if (k == 99) chk("m0_wait", 64'd0, 64'd1);
          end
          @(posedge clk); #1;
          m0_req = 0;
        end
      end
      begin : mst1
        for (int n = 0; n < NTX; n++) begin
          idle1 = (n == 0) ? 0 : $urandom_range(0, 3);
          repeat (idle1) begin @(posedge clk); #1; end
          m1_wr = $urandom; m1_size = $urandom;
          m1_addr = $urandom; m1_wdata = $urandom;
          m1_req = 1;
          for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m1_done) break;
            if (k == 99) chk("m1_wait", 64'd0, 64'd1);
          end
          @(posedge clk); #1;
          m1_req = 0;
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk_on = 0;

    // Reset during BUSY abandons the transaction and restarts the tie order.
    m0_addr = 32'h100; m0_wr = 0; m0_req = 1;
    t = 0;
    while (!bus_req && t < 20) begin @(negedge clk); t++; end
    chk("rst_test_busy", 64'(bus_req), 64'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_bus_req", 64'(bus_req), 64'd0);
    chk("mid_rst_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
    chk("mid_rst_done", 64'({m0_done, m1_done}), 64'd0);
    chk("mid_rst_rdata", 64'(m0_rdata), 64'd0);
    m1_addr = 32'h200; m1_wr = 1; m1_wdata = 32'h1234_5678;
    m1_req = 1;
    @(posedge clk); #1;
    chk("tie_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("tie_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("tie_addr", 64'(bus_addr), 64'h200);
    chk("tie_wdata", 64'(bus_wdata), 64'h1234_5678);
    t = 0;
    while (!m1_done && t < 100) begin @(negedge clk); t++; end
    chk("tie_m1_done", 64'(m1_done), 64'd1);
    @(posedge clk); #1;
    m1_req = 0;
    t = 0;
    while (!m0_done && t < 100) begin @(negedge clk); t++; end
    chk("tie_m0_done", 64'(m0_done), 64'd1);
    @(posedge clk); #1;
    m0_req = 0;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Two-master arbiter and transaction sequencer for the shared system bus. It sits between the hart's load/store port (master 0) and the debug module's system bus access engine (master 1), and presents a single request/acknowledge master to the bus fabric. It serialises transactions with round-robin tie-breaking, registers responses, and can abort hung transactions with a watchdog.

## Interface
Parameters:
- AddrWidth, 32, width of address buses
- DataWidth, 32, width of data buses
- TimeoutCycles, 255, watchdog limit in cycles (1..65535); used only with the watchdog compiled in

Ports (x = 0 for hart, x = 1 for debug):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mx_req  in  1  master x requests a transaction; held high until mx_done
- mx_wr  in  1  1 = write, 0 = read; stable while mx_req
- mx_size  in  3  sign/size code, forwarded unchanged; stable while mx_req
- mx_addr  in  AddrWidth  address; stable while mx_req
- mx_wdata  in  DataWidth  write data; stable while mx_req
- mx_gnt  out  1  master x owns the bus (BUSY or RESP for x)
- mx_done  out  1  one-cycle completion pulse
- mx_rdata  out  DataWidth  read data, valid when mx_done
- mx_fault  out  1  transaction failed, valid when mx_done
- bus_req  out  1  transaction request to the fabric
- bus_wr, bus_size, bus_addr, bus_wdata  out  1/3/AddrWidth/DataWidth  muxed from the granted master
- bus_ack  in  1  fabric completion, one-cycle pulse
- bus_err  in  1  fabric error, qualified by bus_ack
- bus_rdata  in  DataWidth  fabric read data, qualified by bus_ack

## Operation
- States: IDLE, BUSY, RESP. An `owner` register (1 bit) holds the granted master. A `last` register holds the most recent winner.
- IDLE: if exactly one mx_req is high, grant it. If both are high, grant !last. Go to BUSY with owner set and last updated. No request: stay in IDLE.
- BUSY: bus_req = 1, and the bus_* attributes are muxed combinationally from owner. On bus_ack: capture bus_rdata and capture bus_err as fault, then go to RESP.
- RESP: m[owner]_done = 1, rdata and fault driven from the capture registers, bus_req = 0. Next state is IDLE.
- Outputs for a non-owner master: gnt = 0, done = 0, fault = 0. rdata for a non-owner is 0.
- Write transactions: the captured rdata is whatever bus_rdata carries; the master ignores it.
- bus_ack outside BUSY is ignored. A master dropping req mid-transaction does not abort it; done is still pulsed.
- Masters must hold mx_req until their done pulse; the arbiter does not guard against a violation.
- Reset values: state = IDLE, owner = 0, last = 0, capture registers = 0. Hence all outputs are 0, and master 1 wins the first tie.

## Timing
- Request seen in IDLE at cycle N: gnt and bus_req are high from N+1.
- bus_ack at cycle K: done pulses at K+1 and the arbiter is back in IDLE at K+2.
- Minimum occupancy per transaction is 3 cycles (ack in the first BUSY cycle). This means two masters with continuous requests alternate grants every 3 cycles.
- A request that arrives during BUSY/RESP is evaluated in the next IDLE cycle.
- rst is dominant in any state: the next cycle is IDLE with no done pulse, and an in-flight bus transaction is abandoned.

## Configuration
- Macro SYS_BUS_ARBITER_TIMEOUT_EN enables the watchdog.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without bus_ack.
  - When it reaches TimeoutCycles, the next state is RESP with fault = 1 and rdata = 0.
  - bus_ack in the same cycle as the limit wins, and the transaction completes normally.
  - A late ack is ignored.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - mx_fault reflects bus_err only.

## Test plan
- Single read, m0: m0_req with addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> bus_req high for 2 cycles, m0_done pulses 1 cycle after ack with rdata 0xDEADBEEF and fault 0; m1_gnt stays 0.
- Tie after reset: m0_req and m1_req rise together, every ack immediate -> grant order m1, m0, m1, m0; each done 3 cycles apart.
- Bus error: m1 write 0x12345678 to 0x200, ack with bus_err = 1 -> bus_wdata is 0x12345678 during BUSY, m1_done with m1_fault = 1.
- Watchdog (TIMEOUT_EN, TimeoutCycles = 4): no ack -> after 4 BUSY cycles, done with fault = 1 and rdata 0; ack injected 2 cycles later -> ignored, state IDLE.
- Ack at limit (TIMEOUT_EN, TimeoutCycles = 4): ack in the 4th BUSY cycle with bus_err = 0 -> fault = 0, rdata captured.
- Reset mid-transaction: rst asserted in BUSY for 1 cycle -> next cycle all outputs 0, no done pulse; subsequent tie grants m1 first.
